// File: rtl/axis_ascon_release_buffer.sv
// Decrypt-side release buffer: holds one plaintext packet until its tag-check word arrives.
// Optional macro ASCON_RELEASE_BUFFER_ZEROIZE_EN scrubs discarded packets from the FIFO.
module axis_ascon_release_buffer #(
  parameter int aw = 6,
  parameter int dw = 128,
  parameter int kw = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic          s_tlast,
  input  logic [dw-1:0] s_tdata,
  input  logic [kw-1:0] s_tkeep,
  input  logic          s_tag_tvalid,
  output logic          s_tag_tready,
  input  logic [127:0]  s_tag_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic [dw-1:0] m_tdata,
  output logic [kw-1:0] m_tkeep,
  output logic          m_stat_tvalid,
  input  logic          m_stat_tready,
  output logic [1:0]    m_stat_tdata,
  output logic [2:0]    dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // A source never drops valid or changes its payload before that edge; readies here
  // depend only on the registered state, never on the same-cycle valid.

  localparam int depth = 1 << aw;
  localparam int bw = 1 + dw + kw;
  localparam logic [aw:0]   full_cnt = (aw+1)'(depth);
  localparam logic [aw:0]   cnt_one  = (aw+1)'(1);
  localparam logic [aw-1:0] ptr_one  = aw'(1);

  typedef enum logic [2:0] {
    RECV     = 3'd0,
    OVF      = 3'd1,
    WAIT_TAG = 3'd2,
    STAT     = 3'd3,
`ifdef ASCON_RELEASE_BUFFER_ZEROIZE_EN
    ZERO     = 3'd5,
`endif
    DRAIN    = 3'd4
  } state_t;

  state_t          state;
  logic [aw-1:0]   wptr;
  logic [aw-1:0]   rptr;
  logic [aw:0]     count;
  logic            ovf;
  logic [bw-1:0]   mem [depth];
  logic [bw-1:0]   rd_word;
  logic            wr_en;
  logic            drain_load;

  assign s_tready     = (state == RECV) || (state == OVF);
  assign s_tag_tready = (state == WAIT_TAG);
  assign dbg_state    = state;

  assign wr_en   = (state == RECV) && s_tvalid;
  assign rd_word = mem[rptr];
  // Refill the output register whenever it is empty or being emptied this cycle.
  assign drain_load = (state == DRAIN) && (count != '0) && (!m_tvalid || m_tready);

  // Storage has no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= {s_tlast, s_tdata, s_tkeep};
    end
`ifdef ASCON_RELEASE_BUFFER_ZEROIZE_EN
    else if (state == ZERO) begin
      mem[rptr] <= '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RECV;
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      ovf           <= 1'b0;
      m_tvalid      <= 1'b0;
      m_tlast       <= 1'b0;
      m_tdata       <= '0;
      m_tkeep       <= '0;
      m_stat_tvalid <= 1'b0;
      m_stat_tdata  <= '0;
    end else begin
      case (state)
        RECV: begin
          if (s_tvalid) begin
            wptr  <= wptr + ptr_one;
            count <= count + cnt_one;
            if (s_tlast) begin
              state <= WAIT_TAG;
              ovf   <= 1'b0;
            end else if (count == full_cnt - cnt_one) begin
              state <= OVF;
            end
          end
        end
        OVF: begin
          if (s_tvalid && s_tlast) begin
            state <= WAIT_TAG;
            ovf   <= 1'b1;
          end
        end
        WAIT_TAG: begin
          if (s_tag_tvalid) begin
            m_stat_tvalid <= 1'b1;
            m_stat_tdata  <= {ovf, (s_tag_tdata == '0) && !ovf};
            state         <= STAT;
          end
        end
        STAT: begin
          if (m_stat_tready) begin
            m_stat_tvalid <= 1'b0;
            ovf           <= 1'b0;
            if (m_stat_tdata[0]) begin
              state <= DRAIN;
            end else begin
`ifdef ASCON_RELEASE_BUFFER_ZEROIZE_EN
              state <= ZERO;
`else
              rptr  <= wptr;
              count <= '0;
              state <= RECV;
`endif
            end
          end
        end
        DRAIN: begin
          if (drain_load) begin
            m_tvalid                    <= 1'b1;
            {m_tlast, m_tdata, m_tkeep} <= rd_word;
            rptr                        <= rptr + ptr_one;
            count                       <= count - cnt_one;
          end else if (m_tvalid && m_tready) begin
            m_tvalid <= 1'b0;
          end
          if (m_tvalid && m_tready && m_tlast) begin
            state <= RECV;
          end
        end
`ifdef ASCON_RELEASE_BUFFER_ZEROIZE_EN
        ZERO: begin
          // One slot scrubbed per cycle; the final slot also rewinds the pointers.
          if (count <= cnt_one) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            state <= RECV;
          end else begin
            rptr  <= rptr + ptr_one;
            count <= count - cnt_one;
          end
        end
`endif
        default: state <= RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_ascon_release_buffer.sv
// Bench for axis_ascon_release_buffer (D=4): vector table, timing sequences, random traffic.
module tb_axis_ascon_release_buffer;

  localparam int AW = 2;
  localparam int DW = 128;
  localparam int KW = 16;
  localparam int D  = 1 << AW;
  localparam int BW = 1 + DW + KW;
  localparam int NV = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tag_tvalid, s_tag_tready;
  logic [127:0]  s_tag_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_stat_tvalid, m_stat_tready;
  logic [1:0]    m_stat_tdata;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int out_cnt = 0;
  int stat_cnt = 0;
  int tag_cnt = 0;
  bit bp_en = 1'b0;

  logic [BW-1:0] exp_q[$];
  logic [1:0]    stat_q[$];

  typedef struct {
    int           len;
    logic [127:0] tag;
    logic [1:0]   exp_stat;
    int           exp_beats;
  } vec_t;
  vec_t vecs[NV];

  axis_ascon_release_buffer #(.aw(AW), .dw(DW), .kw(KW)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tag_tvalid(s_tag_tvalid), .s_tag_tready(s_tag_tready), .s_tag_tdata(s_tag_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_stat_tvalid(m_stat_tvalid), .m_stat_tready(m_stat_tready), .m_stat_tdata(m_stat_tdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: status from packet length and tag only.
  function automatic logic [1:0] model_stat(input int len, input logic [127:0] tag);
    logic ovf, pass;
    ovf  = (len > D);
    pass = (tag == 128'h0) && !ovf;
    return {ovf, pass};
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    int n;
    n = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
    @(negedge clk);
    while (!s_tready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (!s_tready) chk("s_tready_timeout", s_tready, 1);
    sync();
    s_tvalid = 1'b0;
  endtask

  task automatic send_tag(input logic [127:0] tag, output int hs_cyc);
    int n;
    n = 0;
    s_tag_tvalid = 1'b1; s_tag_tdata = tag;
    @(negedge clk);
    while (!s_tag_tready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (!s_tag_tready) chk("tag_tready_timeout", s_tag_tready, 1);
    hs_cyc = cyc;
    sync();
    s_tag_tvalid = 1'b0;
  endtask

  // Pushes expectations first, then drives the packet and its tag.
  task automatic send_pkt(input int len, input logic [127:0] tag, input logic [1:0] exp_stat);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [BW-1:0] beats[$];
    int hs;
    for (int b = 0; b < len; b++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      k = KW'($urandom);
      beats.push_back({(b == len - 1), d, k});
    end
    stat_q.push_back(exp_stat);
    if (exp_stat[0]) begin
      foreach (beats[i]) exp_q.push_back(beats[i]);
    end
    foreach (beats[i]) send_beat(beats[i][BW-2:KW], beats[i][KW-1:0], beats[i][BW-1]);
    send_tag(tag, hs);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || stat_q.size() != 0 || !s_tready) && n < 2000) begin
      sync();
      n++;
    end
    if (n >= 2000) chk("idle_timeout", exp_q.size() + stat_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string pfx);
    chk($sformatf("%s_s_tready", pfx), s_tready, 1);
    chk($sformatf("%s_s_tag_tready", pfx), s_tag_tready, 0);
    chk($sformatf("%s_m_tvalid", pfx), m_tvalid, 0);
    chk($sformatf("%s_m_tlast", pfx), m_tlast, 0);
    chk($sformatf("%s_m_tdata", pfx), m_tdata, 0);
    chk($sformatf("%s_m_tkeep", pfx), m_tkeep, 0);
    chk($sformatf("%s_m_stat_tvalid", pfx), m_stat_tvalid, 0);
    chk($sformatf("%s_m_stat_tdata", pfx), m_stat_tdata, 0);
    chk($sformatf("%s_state", pfx), dbg_state, 0);
  endtask

  // scoreboard: compares every output/status handshake and checks payload hold under stall
  task automatic monitor();
    logic pv, pr, psv, psr;
    logic [BW-1:0] pbeat;
    logic [1:0] pstat;
    pv = 1'b0; pr = 1'b0; psv = 1'b0; psr = 1'b0; pbeat = '0; pstat = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        psv = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("m_hold_valid", m_tvalid, 1);
          chk("m_hold_beat", {m_tlast, m_tdata, m_tkeep}, pbeat);
        end
        if (psv && !psr) begin
          chk("stat_hold_valid", m_stat_tvalid, 1);
          chk("stat_hold_data", m_stat_tdata, pstat);
        end
        if (m_tvalid && m_tready) begin
          out_cnt++;
          if (exp_q.size() == 0) chk("unexpected_beat", {m_tlast, m_tdata, m_tkeep}, 0);
          else chk("out_beat", {m_tlast, m_tdata, m_tkeep}, exp_q.pop_front());
        end
        if (m_stat_tvalid && m_stat_tready) begin
          stat_cnt++;
          if (stat_q.size() == 0) chk("unexpected_stat", {1'b1, m_stat_tdata}, 0);
          else chk("stat_value", m_stat_tdata, stat_q.pop_front());
        end
        if (s_tag_tvalid && s_tag_tready) tag_cnt++;
        pv = m_tvalid; pr = m_tready; pbeat = {m_tlast, m_tdata, m_tkeep};
        psv = m_stat_tvalid; psr = m_stat_tready; pstat = m_stat_tdata;
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      sync();
      m_tready      = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      m_stat_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  initial begin
    logic [DW-1:0] pd;
    logic [KW-1:0] pk[3];
    logic [127:0]  tag;
    logic [1:0]    st;
    int out_base, stat_base, tag_base, n, t_cyc, s_cyc, low, exp_low, exp_out, len;

    vecs[0] = '{1, 128'h0, 2'b01, 1};
    vecs[1] = '{2, 128'h1, 2'b00, 0};
    vecs[2] = '{7, 128'h0, 2'b10, 0};
    vecs[3] = '{4, 128'h0, 2'b01, 4};
    vecs[4] = '{5, 128'h0, 2'b10, 0};
    vecs[5] = '{7, 128'h1, 2'b10, 0};
    vecs[6] = '{3, {1'b1, 127'h0}, 2'b00, 0};
    vecs[7] = '{4, 128'h5, 2'b00, 0};
    vecs[8] = '{2, 128'h0, 2'b01, 2};
    vecs[9] = '{D, 128'h0, 2'b01, D};

    rst = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0;
    s_tag_tvalid = 1'b0; s_tag_tdata = '0;
    m_tready = 1'b1; m_stat_tready = 1'b1;
    fork
      monitor();
      ready_driver();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    sync();
    check_reset_vals("idle");

    // pass: 3 beats, explicit keeps, latency of status and first output beat
    pk[0] = 16'hFFFF; pk[1] = 16'hFFFF; pk[2] = 16'h00FF;
    out_base = out_cnt;
    stat_q.push_back(2'b01);
    for (int b = 0; b < 3; b++) begin
      pd = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back({(b == 2), pd, pk[b]});
      send_beat(pd, pk[b], (b == 2));
    end
    send_tag(128'h0, t_cyc);
    n = 0;
    @(negedge clk);
    while (!m_stat_tvalid && n < 50) begin n++; @(negedge clk); end
    chk("pass_stat_latency", cyc - t_cyc, 1);
    s_cyc = cyc;
    n = 0;
    @(negedge clk);
    while (!m_tvalid && n < 50) begin n++; @(negedge clk); end
    chk("pass_first_valid_latency", cyc - s_cyc, 2);
    @(negedge clk);
    chk("pass_beat2_valid", m_tvalid, 1);
    @(negedge clk);
    chk("pass_beat3_valid", m_tvalid, 1);
    chk("pass_beat3_last", m_tlast, 1);
    @(negedge clk);
    chk("pass_s_tready_after_last", s_tready, 1);
    chk("pass_m_tvalid_after_last", m_tvalid, 0);
    sync();
    wait_idle();
    chk("pass_beats", out_cnt - out_base, 3);

    // fail then pass; s_tready low time after the status handshake
    out_base = out_cnt;
    send_pkt(2, 128'h1, 2'b00);
    n = 0;
    @(negedge clk);
    while (!(m_stat_tvalid && m_stat_tready) && n < 50) begin n++; @(negedge clk); end
    low = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_tready) break;
      low++;
    end
`ifdef ASCON_RELEASE_BUFFER_ZEROIZE_EN
    exp_low = 2;
`else
    exp_low = 0;
`endif
    chk("fail_s_tready_low_cycles", low, exp_low);
    sync();
    wait_idle();
    chk("fail_no_output", out_cnt - out_base, 0);
    out_base = out_cnt;
    send_pkt(1, 128'h0, 2'b01);
    wait_idle();
    chk("after_fail_pass_beats", out_cnt - out_base, 1);

    // vector table, including overflow followed by an exact-fit packet
    for (int i = 0; i < NV; i++) begin
      out_base = out_cnt;
      stat_base = stat_cnt;
      send_pkt(vecs[i].len, vecs[i].tag, vecs[i].exp_stat);
      wait_idle();
      chk($sformatf("vec%0d_beats", i), out_cnt - out_base, vecs[i].exp_beats);
      chk($sformatf("vec%0d_stats", i), stat_cnt - stat_base, 1);
    end

    // early tag: held valid from before the packet, must be taken exactly once
    tag_base = tag_cnt;
    out_base = out_cnt;
    stat_q.push_back(2'b01);
    s_tag_tvalid = 1'b1;
    s_tag_tdata = '0;
    for (int c = 0; c < 6; c++) begin
      if (c >= 3) begin
        pd = {$urandom, $urandom, $urandom, $urandom};
        pk[0] = KW'($urandom);
        exp_q.push_back({(c == 5), pd, pk[0]});
        s_tvalid = 1'b1; s_tdata = pd; s_tkeep = pk[0]; s_tlast = (c == 5);
      end
      @(negedge clk);
      chk($sformatf("early_tag_tready_c%0d", c), s_tag_tready, 0);
      sync();
    end
    s_tvalid = 1'b0;
    wait_idle();
    repeat (3) sync();
    s_tag_tvalid = 1'b0;
    sync();
    chk("early_tag_accept_count", tag_cnt - tag_base, 1);
    chk("early_tag_beats", out_cnt - out_base, 3);

    // random traffic with backpressure against the model
    bp_en = 1'b1;
    out_base = out_cnt;
    stat_base = stat_cnt;
    exp_out = 0;
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(1, 2 * D - 1);
      if ($urandom_range(0, 1) == 0) tag = '0;
      else begin
        tag = {$urandom, $urandom, $urandom, $urandom};
        if (tag == '0) tag = 128'h1;
      end
      st = model_stat(len, tag);
      if (st[0]) exp_out += len;
      send_pkt(len, tag, st);
    end
    wait_idle();
    bp_en = 1'b0;
    repeat (2) sync();
    chk("random_stat_count", stat_cnt - stat_base, 100);
    chk("random_out_beats", out_cnt - out_base, exp_out);

    // reset in the middle of draining a 4-beat packet
    send_pkt(4, 128'h0, 2'b01);
    n = 0;
    @(negedge clk);
    while (!m_tvalid && n < 50) begin n++; @(negedge clk); end
    sync();
    rst = 1'b1;
    #1;
    check_reset_vals("mid_drain_reset");
    exp_q.delete();
    stat_q.delete();
    repeat (2) sync();
    rst = 1'b0;
    sync();
    out_base = out_cnt;
    send_pkt(2, 128'h0, 2'b01);
    wait_idle();
    chk("post_reset_beats", out_cnt - out_base, 2);
    chk("post_reset_queues_empty", exp_q.size() + stat_q.size(), 0);

    repeat (3) sync();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
